// File: rtl/multicycle_core_param_if.sv
// Shared instruction/data memory port: request held with stable addr/we/wdata until the
// acknowledging edge; rdata is valid in the ack cycle.
interface multicycle_core_param_if #(
    parameter int DATA_W = 8
);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/multicycle_core_param.sv
// Multicycle core (FSM, 4-entry RF, ALU, PC/IR/flags): 3-5 cycles per instruction plus one per memory wait cycle.
// Stalls in FETCH/MEM until mem_ack; MCORE_STEP_EN adds a step input that gates each fetch.
module multicycle_core_param #(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic                    clock,
    input  logic                    reset,
`ifdef MCORE_STEP_EN
    input  logic                    step,
`endif
    multicycle_core_param_if.master mem,
    output logic [4*DATA_W-1:0]     regs_flat,
    output logic [DATA_W-1:0]       pc,
    output logic                    n_flag,
    output logic                    z_flag,
    output logic                    halted
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    state_t            state, state_nxt;
    logic [7:0]        ir;
    logic [DATA_W-1:0] pc_q, a_q, b_q, alu_q, mdr_q, alu_res, br_off;
    logic [DATA_W-1:0] rf [4];
    logic              n_q, z_q;
    logic              fetch_go, xfer, br_taken;
    logic [3:0]        op;
    logic [1:0]        r1_sel, r2_sel, dst_sel;
    logic              is_load, is_store, is_add, is_sub, is_nand, is_ori, is_shift;
    logic              is_bz, is_bnz, is_bpz, is_stop, is_alu;

    assign op       = ir[3:0];
    assign r1_sel   = ir[7:6];
    assign r2_sel   = ir[5:4];
    assign is_load  = (op == 4'b0000);
    assign is_store = (op == 4'b0010);
    assign is_add   = (op == 4'b0100);
    assign is_sub   = (op == 4'b0110);
    assign is_nand  = (op == 4'b1000);
    assign is_ori   = (op[2:0] == 3'b111);
    assign is_shift = (op[2:0] == 3'b011);
    assign is_bz    = (op == 4'b0101);
    assign is_bnz   = (op == 4'b1001);
    assign is_bpz   = (op == 4'b1101);
    assign is_stop  = (op == 4'b0001);
    assign is_alu   = is_add | is_sub | is_nand | is_ori | is_shift;
    // ORI always reads and writes r1 regardless of the R1 field
    assign dst_sel  = is_ori ? 2'd1 : r1_sel;

    assign br_taken = (is_bz & z_q) | (is_bnz & ~z_q) | (is_bpz & ~n_q);
    assign br_off   = {{(DATA_W-4){ir[7]}}, ir[7:4]};
    assign xfer     = mem.mem_req & mem.mem_ack;

`ifdef MCORE_STEP_EN
    logic armed;
    assign fetch_go = armed;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            armed <= 1'b0;
        end else if (state == S_FETCH) begin
            if (xfer)
                armed <= 1'b0;
            else if (step)
                armed <= 1'b1;
        end
    end
`else
    assign fetch_go = 1'b1;
`endif

    always_comb begin
        alu_res = a_q;
        if (is_add)
            alu_res = a_q + b_q;
        else if (is_sub)
            alu_res = a_q - b_q;
        else if (is_nand)
            alu_res = ~(a_q & b_q);
        else if (is_ori)
            alu_res = a_q | DATA_W'(ir[7:3]);
        else if (is_shift)
            alu_res = ir[5] ? (a_q >> ir[4:3]) : (a_q << ir[4:3]);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= S_FETCH;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = pc_q;
        mem.mem_wdata = a_q;
        case (state)
            S_FETCH: begin
                mem.mem_req = fetch_go;
                if (fetch_go && mem.mem_ack)
                    state_nxt = S_DECODE;
            end
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                if (is_alu)
                    state_nxt = S_WB;
                else if (is_load || is_store)
                    state_nxt = S_MEM;
                else if (is_stop)
                    state_nxt = S_HALT;
                else
                    state_nxt = S_FETCH;
            end
            S_MEM: begin
                mem.mem_req  = 1'b1;
                mem.mem_we   = is_store;
                mem.mem_addr = b_q;
                if (mem.mem_ack)
                    state_nxt = is_load ? S_WB : S_FETCH;
            end
            S_WB:    state_nxt = S_FETCH;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
        // Request must fall with reset, not at the next edge
        if (reset)
            mem.mem_req = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            ir    <= '0;
            a_q   <= '0;
            b_q   <= '0;
            alu_q <= '0;
            mdr_q <= '0;
            n_q   <= 1'b0;
            z_q   <= 1'b0;
            for (int i = 0; i < 4; i++)
                rf[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (xfer) begin
                        ir   <= mem.mem_rdata[7:0];
                        pc_q <= pc_q + ONE;
                    end
                end
                S_DECODE: begin
                    a_q <= rf[dst_sel];
                    b_q <= rf[r2_sel];
                end
                S_EXEC: begin
                    if (is_alu) begin
                        alu_q <= alu_res;
                        n_q   <= alu_res[DATA_W-1];
                        z_q   <= (alu_res == '0);
                    end
                    // pc already points past the branch, so the offset is relative to fetch addr+1
                    if (br_taken)
                        pc_q <= pc_q + br_off;
                end
                S_MEM: begin
                    if (xfer && is_load)
                        mdr_q <= mem.mem_rdata;
                end
                S_WB: rf[dst_sel] <= is_load ? mdr_q : alu_q;
                default: ;
            endcase
        end
    end

    assign regs_flat = {rf[3], rf[2], rf[1], rf[0]};
    assign pc        = pc_q;
    assign n_flag    = n_q;
    assign z_flag    = z_q;
    assign halted    = (state == S_HALT);
endmodule

// File: tb/tb_multicycle_core_param.sv
// Directed bench for multicycle_core_param (DATA_W=8): memory model with programmable wait states.
module tb_multicycle_core_param;
    localparam int DW = 8;
`ifdef MCORE_STEP_EN
    localparam int STEP_EXTRA = 1;
`else
    localparam int STEP_EXTRA = 0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    multicycle_core_param_if #(.DATA_W(DW)) mif ();
    logic [4*DW-1:0] regs_flat;
    logic [DW-1:0]   pc;
    logic            n_flag, z_flag, halted;
`ifdef MCORE_STEP_EN
    logic step = 1'b1;
`endif

    multicycle_core_param #(.DATA_W(DW), .RESET_PC(8'h00)) dut (
        .clock     (clock),
        .reset     (reset),
`ifdef MCORE_STEP_EN
        .step      (step),
`endif
        .mem       (mif),
        .regs_flat (regs_flat),
        .pc        (pc),
        .n_flag    (n_flag),
        .z_flag    (z_flag),
        .halted    (halted)
    );

    logic [7:0] mem_arr [256];
    logic [7:0] img [256];
    logic       ld_en = 1'b0;
    logic       ack_force = 1'b0;
    int         wait_n = 0;
    logic [7:0] wcnt = 8'h00;
    int         n_cmp = 0;
    int         n_bad = 0;

    assign mif.mem_ack   = ack_force | (mif.mem_req && (wcnt == wait_n[7:0]));
    assign mif.mem_rdata = mem_arr[mif.mem_addr];

    always @(posedge clock) begin
        if (ld_en)
            mem_arr <= img;
        else if (mif.mem_req && mif.mem_ack && mif.mem_we)
            mem_arr[mif.mem_addr] <= mif.mem_wdata;
        if (mif.mem_req && !mif.mem_ack)
            wcnt <= wcnt + 8'd1;
        else
            wcnt <= 8'h00;
    end

    // Request attributes must not move while a transaction is waiting for ack
    logic       hold_vld = 1'b0;
    logic       hold_we;
    logic [7:0] hold_addr, hold_wd;
    int         stab_err = 0;
    always @(posedge clock) begin
        if (reset)
            hold_vld <= 1'b0;
        else if (mif.mem_req && !mif.mem_ack) begin
            hold_vld  <= 1'b1;
            hold_we   <= mif.mem_we;
            hold_addr <= mif.mem_addr;
            hold_wd   <= mif.mem_wdata;
        end else
            hold_vld <= 1'b0;
    end
    always @(negedge clock)
        if (hold_vld && mif.mem_req &&
            (mif.mem_addr !== hold_addr || mif.mem_we !== hold_we || mif.mem_wdata !== hold_wd))
            stab_err++;

    task automatic clear_img();
        for (int i = 0; i < 256; i++)
            img[i] = 8'h0A;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ld_en = 1'b1;
        @(negedge clock);
        @(negedge clock);
        ld_en = 1'b0;
        reset = 1'b0;
    endtask

    task automatic next_fetch(output logic [7:0] addr, output int cyc, output bit ok);
        logic prev, cur;
        prev = mif.mem_req && !mif.mem_we && (mif.mem_addr == pc);
        addr = 8'h00;
        cyc  = 0;
        ok   = 1'b0;
        while (!ok && cyc < 60) begin
            @(negedge clock);
            cyc++;
            cur = mif.mem_req && !mif.mem_we && (mif.mem_addr == pc);
            if (cur && !prev) begin
                addr = mif.mem_addr;
                ok   = 1'b1;
            end
            prev = cur;
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL fetch_timeout: no new fetch after %0d cycles, required one within 60", cyc);
        end
    endtask

    task automatic wait_fetch_at(input logic [7:0] a, output int cyc);
        logic [7:0] ad;
        bit         ok;
        int         k;
        ad = ~a; ok = 1'b1; cyc = 0; k = 0;
        while (ok && ad !== a && k < 40) begin
            next_fetch(ad, cyc, ok);
            k++;
        end
        if (ok && ad !== a) begin
            n_cmp++; n_bad++;
            $display("FAIL fetch_at: last fetch %02h, required a fetch of %02h", ad, a);
        end
    endtask

    task automatic test_reset();
        int c;
        clear_img();
        img[0] = 8'h87; img[1] = 8'h10; img[2] = 8'h0F; img[8'h10] = 8'h05;
        wait_n = 3;
        reset = 1'b1; ld_en = 1'b1;
        @(negedge clock);
        n_cmp++; if (mif.mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b, required 0", mif.mem_req); end
        n_cmp++; if (pc !== 8'h00) begin n_bad++; $display("FAIL rst_pc: got %02h, required 00", pc); end
        n_cmp++; if ({regs_flat, n_flag, z_flag, halted} !== 35'h0) begin n_bad++; $display("FAIL rst_state: regs %08h nzh %b%b%b, required all 0", regs_flat, n_flag, z_flag, halted); end
        @(negedge clock);
        ld_en = 1'b0; reset = 1'b0;
        wait_fetch_at(8'h02, c);
        n_cmp++; if (regs_flat !== 32'h0000_1005) begin n_bad++; $display("FAIL pre_rst_regs: got %08h, required 00001005", regs_flat); end
        @(negedge clock);
        n_cmp++; if (mif.mem_req !== 1'b1) begin n_bad++; $display("FAIL midfetch_req: got %b, required 1", mif.mem_req); end
        reset = 1'b1;
        #1;
        n_cmp++; if (mif.mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_drop_req: got %b, required 0", mif.mem_req); end
        n_cmp++; if ({pc, regs_flat, halted} !== 41'h0) begin n_bad++; $display("FAIL rst_clear: pc %02h regs %08h halted %b, required 0", pc, regs_flat, halted); end
    endtask

    task automatic test_add();
        int c;
        clear_img();
        img[0] = 8'h87; img[1] = 8'h10; img[2] = 8'h0F; img[3] = 8'h50; img[4] = 8'h14;
        img[8'h10] = 8'h05; img[8'h11] = 8'hFA;
        wait_n = 0;
        do_reset();
        wait_fetch_at(8'h04, c);
        wait_fetch_at(8'h05, c);
        n_cmp++; if (c !== 4 + STEP_EXTRA) begin n_bad++; $display("FAIL add_cycles: got %0d, required %0d", c, 4 + STEP_EXTRA); end
        n_cmp++; if (regs_flat !== 32'h0000_FAFF) begin n_bad++; $display("FAIL add_regs: got %08h, required 0000faff", regs_flat); end
        n_cmp++; if ({n_flag, z_flag} !== 2'b10) begin n_bad++; $display("FAIL add_flags: got nz=%b%b, required 10", n_flag, z_flag); end
        n_cmp++; if (pc !== 8'h05) begin n_bad++; $display("FAIL add_pc: got %02h, required 05", pc); end
    endtask

    task automatic test_alu_ops();
        int c, lat;
        clear_img();
        img[0] = 8'h67; img[1] = 8'h53; img[2] = 8'h7B; img[3] = 8'h56;
        img[4] = 8'h08; img[5] = 8'h86; img[6] = 8'h03; img[7] = 8'h01;
        wait_n = 0;
        do_reset();
        wait_fetch_at(8'h03, c);
        n_cmp++; if (regs_flat !== 32'h0000_0600) begin n_bad++; $display("FAIL shift_regs: got %08h, required 00000600", regs_flat); end
        wait_fetch_at(8'h04, c);
        n_cmp++; if ({regs_flat[15:8], n_flag, z_flag} !== 10'b00000000_01) begin n_bad++; $display("FAIL sub_zero: r1 %02h nz=%b%b, required r1 00 nz=01", regs_flat[15:8], n_flag, z_flag); end
        wait_fetch_at(8'h06, c);
        n_cmp++; if ({regs_flat, n_flag, z_flag} !== {32'h0001_00FF, 2'b00}) begin n_bad++; $display("FAIL nand_sub: regs %08h nz=%b%b, required 000100ff nz=00", regs_flat, n_flag, z_flag); end
        wait_fetch_at(8'h07, c);
        n_cmp++; if ({regs_flat, n_flag, z_flag} !== {32'h0001_00FF, 2'b10}) begin n_bad++; $display("FAIL shift0: regs %08h nz=%b%b, required 000100ff nz=10", regs_flat, n_flag, z_flag); end
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clock);
            if (halted === 1'b1) lat = k;
        end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL halt_latency: got %0d, required 3", lat); end
    endtask

    task automatic test_halt();
        int req_seen;
        req_seen = 0;
        for (int i = 0; i < 20; i++) begin
            ack_force = (i % 2 == 0);
            @(negedge clock);
            if (mif.mem_req !== 1'b0) req_seen++;
        end
        ack_force = 1'b0;
        n_cmp++; if (req_seen !== 0) begin n_bad++; $display("FAIL halt_req: got %0d request cycles, required 0", req_seen); end
        n_cmp++; if ({halted, pc, regs_flat} !== {1'b1, 8'h08, 32'h0001_00FF}) begin n_bad++; $display("FAIL halt_hold: halted %b pc %02h regs %08h, required 1 08 000100ff", halted, pc, regs_flat); end
    endtask

    task automatic test_load_store();
        int c;
        clear_img();
        img[0] = 8'h87; img[1] = 8'h90; img[2] = 8'h0F; img[3] = 8'h50;
        img[4] = 8'h62; img[5] = 8'hE0; img[6] = 8'h01;
        img[8'h10] = 8'h20; img[8'h11] = 8'hAA;
        wait_n = 3;
        do_reset();
        wait_fetch_at(8'h04, c);
        wait_fetch_at(8'h05, c);
        n_cmp++; if (c !== 10 + STEP_EXTRA) begin n_bad++; $display("FAIL store_cycles: got %0d, required %0d", c, 10 + STEP_EXTRA); end
        n_cmp++; if (mem_arr[8'h20] !== 8'hAA) begin n_bad++; $display("FAIL store_data: got %02h, required aa", mem_arr[8'h20]); end
        wait_fetch_at(8'h06, c);
        n_cmp++; if (c !== 11 + STEP_EXTRA) begin n_bad++; $display("FAIL load_cycles: got %0d, required %0d", c, 11 + STEP_EXTRA); end
        n_cmp++; if (regs_flat !== 32'hAA20_AA00) begin n_bad++; $display("FAIL load_regs: got %08h, required aa20aa00", regs_flat); end
        n_cmp++; if ({n_flag, z_flag} !== 2'b00) begin n_bad++; $display("FAIL load_flags: got nz=%b%b, required 00", n_flag, z_flag); end
        n_cmp++; if (stab_err !== 0) begin n_bad++; $display("FAIL req_stable: got %0d unstable cycles, required 0", stab_err); end
        wait_n = 0;
    endtask

    task automatic test_branch();
        logic [7:0] exp_a [6];
        logic [7:0] a;
        int         c;
        bit         ok;
        exp_a = '{8'h05, 8'h06, 8'h0E, 8'h0F, 8'h10, 8'h0F};
        clear_img();
        img[0] = 8'h06; img[1] = 8'h3D; img[5] = 8'h79; img[6] = 8'h75;
        img[8'h0F] = 8'h79; img[8'h10] = 8'hE5;
        do_reset();
        wait_fetch_at(8'h01, c);
        for (int k = 0; k < 6; k++) begin
            next_fetch(a, c, ok);
            if (!ok) break;
            n_cmp++; if (a !== exp_a[k]) begin n_bad++; $display("FAIL branch_addr%0d: got %02h, required %02h", k, a, exp_a[k]); end
            if (k == 0 || k == 5) begin
                n_cmp++; if (c !== 3 + STEP_EXTRA) begin n_bad++; $display("FAIL branch_cycles%0d: got %0d, required %0d", k, c, 3 + STEP_EXTRA); end
            end
        end
        n_cmp++; if (pc !== 8'h0F) begin n_bad++; $display("FAIL bz_target_pc: got %02h, required 0f", pc); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_a [3];
        logic [7:0] a;
        int         c;
        bit         ok;
        exp_a = '{8'h02, 8'hFF, 8'h00};
        clear_img();
        img[0] = 8'h08; img[1] = 8'h7D; img[2] = 8'hC9;
        do_reset();
        wait_fetch_at(8'h01, c);
        for (int k = 0; k < 3; k++) begin
            next_fetch(a, c, ok);
            if (!ok) break;
            n_cmp++; if (a !== exp_a[k]) begin n_bad++; $display("FAIL wrap_addr%0d: got %02h, required %02h", k, a, exp_a[k]); end
        end
        n_cmp++; if (pc !== 8'h00) begin n_bad++; $display("FAIL wrap_pc: got %02h, required 00", pc); end
    endtask

`ifdef MCORE_STEP_EN
    task automatic test_step();
        int   req_cnt, rises;
        logic prev;
        clear_img();
        img[0] = 8'h87; img[1] = 8'h87;
        step = 1'b0;
        do_reset();
        req_cnt = 0;
        repeat (10) begin
            @(negedge clock);
            if (mif.mem_req !== 1'b0) req_cnt++;
        end
        n_cmp++; if (req_cnt !== 0) begin n_bad++; $display("FAIL step_idle: got %0d request cycles, required 0", req_cnt); end
        step = 1'b1;
        rises = 0; prev = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            step = 1'b0;
            if (mif.mem_req && !prev) rises++;
            prev = mif.mem_req;
        end
        n_cmp++; if (rises !== 1) begin n_bad++; $display("FAIL step_once: got %0d fetches, required 1", rises); end
        n_cmp++; if ({pc, regs_flat} !== {8'h01, 32'h0000_1000}) begin n_bad++; $display("FAIL step_result: pc %02h regs %08h, required 01 00001000", pc, regs_flat); end
        step = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_halt();
        test_load_store();
        test_branch();
        test_wrap();
`ifdef MCORE_STEP_EN
        test_step();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
